// File: rtl/counter_pkg.sv
// Shared types for the mode-selectable counter.
// Mode encoding and direction constants.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP,
    MODE_DOWN,
    MODE_BOUNCE,
    MODE_HOLD
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/mode_counter.sv
// Mode-selectable counter: up/down/bounce/hold, modulo MAX_VAL, wrap or saturate.
// Ports: clk, rst (sync active-low), en, mod, load, load_val -> count, dir, tc, wrap.
module mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mod,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_n;
  logic             dir_n;
  logic             tc_n;
  logic             wrap_n;

  always_comb begin
    count_n = count;
    dir_n   = dir;
    tc_n    = 1'b0;
    wrap_n  = 1'b0;
    if (load) begin
      count_n = (load_val > MAXV) ? MAXV : load_val;
    end else if (en) begin
      unique case (mode_e'(mod))
        MODE_UP: begin
          dir_n = DIR_UP;
          if (count < MAXV) begin
            count_n = count + ONE;
            tc_n    = (count_n == MAXV);
          end else if (!SATURATE) begin
            count_n = ZERO;
            wrap_n  = 1'b1;
          end
        end
        MODE_DOWN: begin
          dir_n = DIR_DOWN;
          if (count > ZERO) begin
            count_n = count - ONE;
            tc_n    = (count_n == ZERO);
          end else if (!SATURATE) begin
            count_n = MAXV;
            wrap_n  = 1'b1;
          end
        end
        MODE_BOUNCE: begin
          if (dir == DIR_UP) begin
            if (count < MAXV) begin
              count_n = count + ONE;
            end else begin
              dir_n   = DIR_DOWN;
              count_n = MAXV - ONE;
            end
          end else begin
            if (count > ZERO) begin
              count_n = count - ONE;
            end else begin
              dir_n   = DIR_UP;
              count_n = ONE;
            end
          end
          // Reaching either end is terminal while bouncing.
          tc_n = (count_n == ZERO) || (count_n == MAXV);
        end
        MODE_HOLD: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      dir   <= DIR_UP;
      tc    <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      count <= count_n;
      dir   <= dir_n;
      tc    <= tc_n;
      wrap  <= wrap_n;
    end
  end

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench for mode_counter (WIDTH=4, MAX_VAL=9).
// Wrap and saturate instances share stimulus; vectors, corner sequences, random vs model.
module tb_mode_counter;

  localparam int W    = 4;
  localparam int MAXV = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mod;
  logic         load;
  logic [W-1:0] load_val;

  logic [W-1:0] count0, count1;
  logic         dir0, dir1, tc0, tc1, wrap0, wrap1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(W), .MAX_VAL(MAXV), .SATURATE(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .mod(mod), .load(load),
    .load_val(load_val), .count(count0), .dir(dir0), .tc(tc0), .wrap(wrap0)
  );

  mode_counter #(.WIDTH(W), .MAX_VAL(MAXV), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .mod(mod), .load(load),
    .load_val(load_val), .count(count1), .dir(dir1), .tc(tc1), .wrap(wrap1)
  );

  typedef struct {
    bit       r;
    bit       e;
    bit [1:0] m;
    bit       l;
    bit [3:0] lv;
    bit [3:0] c;
    bit       d;
    bit       t;
    bit       w;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit e, bit [1:0] m, bit l, bit [3:0] lv,
                              bit [3:0] c, bit d, bit t, bit w);
    vec_t v;
    v.r = r; v.e = e; v.m = m; v.l = l; v.lv = lv;
    v.c = c; v.d = d; v.t = t; v.w = w;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got count=%0d dir=%b tc=%b wrap=%b, expected count=%0d dir=%b tc=%b wrap=%b",
               nm, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(bit r, bit e, bit [1:0] m, bit l, bit [3:0] lv);
    rst = r; en = e; mod = m; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  // Reference: step in current direction; out-of-range steps reflect
  // (bounce), stick (saturate) or wrap modulo MAXV+1.
  task automatic model(input bit sat, input bit r, input bit e, input bit [1:0] m,
                       input bit l, input int lv, inout int c, inout bit d,
                       output bit t, output bit w);
    int step;
    int nx;
    t = 0;
    w = 0;
    if (!r) begin
      c = 0;
      d = 0;
    end else if (l) begin
      c = (lv > MAXV) ? MAXV : lv;
    end else if (e && m != 2'd3) begin
      if (m == 2'd0) d = 0;
      if (m == 2'd1) d = 1;
      step = d ? -1 : 1;
      nx = c + step;
      if (nx < 0 || nx > MAXV) begin
        if (m == 2'd2) begin
          d = !d;
          nx = c - step;
        end else if (sat) begin
          nx = c;
        end else begin
          nx = (nx + MAXV + 1) % (MAXV + 1);
          w = 1;
        end
      end
      if (nx != c)
        t = (m == 2'd2) ? (nx == 0 || nx == MAXV) : (nx == (d ? 0 : MAXV));
      c = nx;
    end
  endtask

  initial begin
    int mc0, mc1;
    bit md0, md1, mt0, mt1, mw0, mw1;
    bit r, e, l;
    bit [1:0] m;
    bit [3:0] lv;

    rst = 1'b0; en = 1'b0; mod = 2'd0; load = 1'b0; load_val = '0;

    // reset overrides load, then count up and wrap
    tbl.push_back(mk(0, 1, 0, 1, 5, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 5, 0, 0, 0, 0));
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(1, 1, 0, 0, 0, 4'(i), 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 9, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1));
    // down wrap
    tbl.push_back(mk(1, 1, 1, 0, 0, 9, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 8, 1, 0, 0));
    // clamped load with en low keeps dir, then reset beats load
    tbl.push_back(mk(1, 0, 1, 1, 15, 9, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 15, 0, 0, 0, 0));
    // bounce from 8 upward
    tbl.push_back(mk(1, 1, 2, 1, 8, 8, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2, 0, 0, 9, 0, 1, 0));
    for (int i = 8; i >= 1; i--)
      tbl.push_back(mk(1, 1, 2, 0, 0, 4'(i), 1, 0, 0));
    tbl.push_back(mk(1, 1, 2, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 2, 0, 0, 1, 0, 0, 0));
    // enable low and hold mode
    tbl.push_back(mk(1, 1, 0, 1, 4, 4, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 4, 0, 0, 0));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(1, 1, 3, 0, 0, 4, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 5, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].l, tbl[i].lv);
      chk($sformatf("tbl%0d", i), {count0, dir0, tc0, wrap0},
          {tbl[i].c, tbl[i].d, tbl[i].t, tbl[i].w});
    end

    // saturating instance: down to 0 then stuck
    drive(1, 1, 1, 1, 2);
    chk("sat_load", {count1, dir1, tc1, wrap1}, {4'd2, 1'b0, 1'b0, 1'b0});
    drive(1, 1, 1, 0, 0);
    chk("sat_dn1", {count1, dir1, tc1, wrap1}, {4'd1, 1'b1, 1'b0, 1'b0});
    drive(1, 1, 1, 0, 0);
    chk("sat_dn0", {count1, dir1, tc1, wrap1}, {4'd0, 1'b1, 1'b1, 1'b0});
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 0);
      chk($sformatf("sat_stuck%0d", i), {count1, dir1, tc1, wrap1},
          {4'd0, 1'b1, 1'b0, 1'b0});
    end
    // saturating up end
    drive(1, 1, 0, 1, 8);
    drive(1, 1, 0, 0, 0);
    chk("sat_up9", {count1, dir1, tc1, wrap1}, {4'd9, 1'b0, 1'b1, 1'b0});
    drive(1, 1, 0, 0, 0);
    chk("sat_upstuck", {count1, dir1, tc1, wrap1}, {4'd9, 1'b0, 1'b0, 1'b0});

    // randomized against the reference model
    mc0 = 0; mc1 = 0; md0 = 0; md1 = 0;
    for (int k = 0; k < 400; k++) begin
      r  = (k == 0) ? 1'b0 : ($urandom_range(0, 19) != 0);
      l  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      m  = 2'($urandom_range(0, 3));
      lv = 4'($urandom_range(0, 15));
      model(1'b0, r, e, m, l, int'(lv), mc0, md0, mt0, mw0);
      model(1'b1, r, e, m, l, int'(lv), mc1, md1, mt1, mw1);
      drive(r, e, m, l, lv);
      chk($sformatf("rnd_wrap%0d", k), {count0, dir0, tc0, wrap0},
          {4'(mc0), md0, mt0, mw0});
      chk($sformatf("rnd_sat%0d", k), {count1, dir1, tc1, wrap1},
          {4'(mc1), md1, mt1, mw1});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
